// File: rtl/user_event_sched_pkg.sv
// Shared definitions for the user event scheduler.
// Holds key bit indices, the EV_* event codes, the repeat FSM state type
// and a helper that maps a key index onto its event code.
package user_event_sched_pkg;

    // Bit positions in key_level_i
    localparam int KEY_LEFT     = 0;
    localparam int KEY_RIGHT    = 1;
    localparam int KEY_DOWN     = 2;
    localparam int KEY_ROTATE   = 3;
    localparam int KEY_NEW_GAME = 4;
    localparam int KEY_CNT      = 5;

    // Game event codes seen by the game logic
    localparam int EV_W = 3;
    localparam logic [EV_W-1:0] EV_NONE     = 3'd0;
    localparam logic [EV_W-1:0] EV_LEFT     = 3'd1;
    localparam logic [EV_W-1:0] EV_RIGHT    = 3'd2;
    localparam logic [EV_W-1:0] EV_DOWN     = 3'd3;
    localparam logic [EV_W-1:0] EV_ROTATE   = 3'd4;
    localparam logic [EV_W-1:0] EV_NEW_GAME = 3'd5;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    function automatic logic [EV_W-1:0] key_to_ev(input int key);
        case (key)
            KEY_LEFT:     return EV_LEFT;
            KEY_RIGHT:    return EV_RIGHT;
            KEY_DOWN:     return EV_DOWN;
            KEY_ROTATE:   return EV_ROTATE;
            KEY_NEW_GAME: return EV_NEW_GAME;
            default:      return EV_NONE;
        endcase
    endfunction

endpackage

// File: rtl/user_event_sched_fifo.sv
// ev_fifo: synchronous FIFO with flush and a registered head word.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        empties the FIFO; a push in the same cycle becomes the sole entry
//   push_i/wdata_i write request and data (accepted if not full, or popping)
//   pop_i          read request (ignored when empty or flushing)
//   head_o         oldest entry, zero when empty
//   full_o/empty_o occupancy flags
module ev_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] head_q;
    logic             push_ok;
    logic             pop_ok;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;
    assign pop_ok  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when a pop frees a slot this cycle
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rd_next = rd_ptr_q + 1'b1;
    assign wr_en   = flush_i ? push_i : push_ok;
    assign wr_addr = flush_i ? '0 : wr_ptr_q;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push_i ? AW'(1) : '0;
            count_q  <= push_i ? (AW+1)'(1) : '0;
            head_q   <= push_i ? wdata_i : '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_next;
            end
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            // Head tracks what will be the oldest entry after this cycle
            if (pop_ok) begin
                if (count_q > (AW+1)'(1)) begin
                    head_q <= mem_q[rd_next];
                end else if (push_ok) begin
                    head_q <= wdata_i;
                end else begin
                    head_q <= '0;
                end
            end else if (empty_o && push_ok) begin
                head_q <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/user_event_sched.sv
// user_event_sched: turns debounced key levels into game events.
// Rising edges and auto-repeat ticks (LEFT/RIGHT/DOWN) set pending bits,
// one pending bit per cycle is granted by fixed priority
// NEW_GAME > ROTATE > LEFT > RIGHT > DOWN and written into an event FIFO.
// Handshake: user_event_ready_o high means user_event_o holds a valid event;
// the event is consumed on a cycle where user_event_rd_req_i and
// user_event_ready_o are both high; rd_req while not ready is ignored.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   key_level_i[4:0]      LEFT, RIGHT, DOWN, ROTATE, NEW_GAME held levels
//   user_event_o          head-of-FIFO event code
//   user_event_ready_o    FIFO not empty
//   user_event_rd_req_i   pop request
//   drop_o                one-cycle pulse when an event was coalesced
module user_event_sched
    import user_event_sched_pkg::*;
#(
    parameter int FIFO_DEPTH        = 4,
    parameter int REPEAT_DELAY_CYC  = 12_500_000,
    parameter int REPEAT_PERIOD_CYC = 4_000_000,
    parameter int CNT_W             = 24
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [KEY_CNT-1:0] key_level_i,
    output logic [EV_W-1:0]    user_event_o,
    output logic               user_event_ready_o,
    input  logic               user_event_rd_req_i,
    output logic               drop_o
);

    logic [KEY_CNT-1:0] key_q;
    logic [KEY_CNT-1:0] pending_q, pending_d;
    logic               drop_q, drop_d;
    rpt_state_e         rpt_state_q;
    logic [1:0]         owner_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [KEY_CNT-1:0] press, set_bits, grant, tick_bits;
    logic [EV_W-1:0]    grant_ev;
    logic               fifo_full, fifo_empty, pop, can_accept, ng_grant;
    logic [3:0]         owner_onehot;
    logic [2:0]         cand;
    logic               cand_any;
    logic [1:0]         cand_owner;
    logic               owner_lvl;
    logic               rpt_tick;

    assign press      = key_level_i & ~key_q;
    assign pop        = user_event_rd_req_i & ~fifo_empty;
    assign can_accept = ~fifo_full | pop;

    // Fixed-priority arbitration over pending bits
    always_comb begin
        grant    = '0;
        grant_ev = EV_NONE;
        if (can_accept) begin
            if (pending_q[KEY_NEW_GAME]) begin
                grant[KEY_NEW_GAME] = 1'b1;
                grant_ev            = key_to_ev(KEY_NEW_GAME);
            end else if (pending_q[KEY_ROTATE]) begin
                grant[KEY_ROTATE] = 1'b1;
                grant_ev          = key_to_ev(KEY_ROTATE);
            end else if (pending_q[KEY_LEFT]) begin
                grant[KEY_LEFT] = 1'b1;
                grant_ev        = key_to_ev(KEY_LEFT);
            end else if (pending_q[KEY_RIGHT]) begin
                grant[KEY_RIGHT] = 1'b1;
                grant_ev         = key_to_ev(KEY_RIGHT);
            end else if (pending_q[KEY_DOWN]) begin
                grant[KEY_DOWN] = 1'b1;
                grant_ev        = key_to_ev(KEY_DOWN);
            end
        end
    end
    assign ng_grant = grant[KEY_NEW_GAME];

    // A fresh press of a repeatable key other than the current owner takes over
    assign owner_onehot = 4'b0001 << owner_q;
    assign cand       = press[2:0] & ~((rpt_state_q == RPT_IDLE) ? 3'b000 : owner_onehot[2:0]);
    assign cand_any   = |cand;
    assign cand_owner = cand[0] ? 2'd0 : (cand[1] ? 2'd1 : 2'd2);
    assign owner_lvl  = key_level_i[owner_q];

    // Owner takeover or release wins over a tick landing in the same cycle
    always_comb begin
        rpt_tick = 1'b0;
        if (!cand_any && owner_lvl) begin
            case (rpt_state_q)
                RPT_DELAY:  rpt_tick = (cnt_q == CNT_W'(REPEAT_DELAY_CYC - 1));
                RPT_REPEAT: rpt_tick = (cnt_q == CNT_W'(REPEAT_PERIOD_CYC - 1));
                default:    rpt_tick = 1'b0;
            endcase
        end
    end

    assign tick_bits = rpt_tick ? {1'b0, owner_onehot} : '0;
    assign set_bits  = press | tick_bits;

    // NEW_GAME wipes every other request; otherwise a new set survives its own grant
    assign pending_d = ng_grant ? (set_bits & (KEY_CNT'(1) << KEY_NEW_GAME))
                                : ((pending_q & ~grant) | set_bits);
    assign drop_d    = ~ng_grant & (|(set_bits & pending_q & ~grant));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q     <= '1;
            pending_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            key_q     <= key_level_i;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    // Auto-repeat FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rpt_state_q <= RPT_IDLE;
            owner_q     <= 2'd0;
            cnt_q       <= '0;
        end else if (ng_grant) begin
            rpt_state_q <= RPT_IDLE;
            cnt_q       <= '0;
        end else if (cand_any) begin
            rpt_state_q <= RPT_DELAY;
            owner_q     <= cand_owner;
            cnt_q       <= '0;
        end else if (rpt_state_q != RPT_IDLE) begin
            if (!owner_lvl) begin
                rpt_state_q <= RPT_IDLE;
                cnt_q       <= '0;
            end else if (rpt_tick) begin
                rpt_state_q <= RPT_REPEAT;
                cnt_q       <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    ev_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(EV_W)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .flush_i(ng_grant),
        .push_i (|grant),
        .wdata_i(grant_ev),
        .pop_i  (pop),
        .head_o (user_event_o),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign user_event_ready_o = ~fifo_empty;
    assign drop_o             = drop_q;

endmodule
